locked_cla_pipe: RTL and testbench

LOCKED_CLA_PIPE -- requirements
Module: locked_cla_pipe

---
 rtl/locked_cla_pipe.sv | 154 +++++++++++++++
 tb/tb_locked_cla_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/locked_cla_pipe.sv
// Key-locked two-stage carry-lookahead adder with a valid/ready pipeline.
// A serially loaded key selects an XOR mask that is folded into every result.
module locked_cla_pipe #(
  parameter int                WIDTH       = 16,
  parameter int                BLOCK       = 4,
  parameter int                KEY_W       = 32,
  parameter logic [KEY_W-1:0]  KEY_CORRECT = 32'hD7D41D23
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             cin_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH:0]   result_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             key_shift_i,
  input  logic             key_bit_i,
  input  logic             key_clear_i,
  output logic             key_armed_o,
  output logic             lock_ok_o
);

  localparam int NGRP  = WIDTH / BLOCK;
  localparam int CNT_W = $clog2(KEY_W + 1);

  if (WIDTH % BLOCK != 0) begin : g_width_check
    $error("locked_cla_pipe: WIDTH must be a multiple of BLOCK");
  end

  typedef enum logic [1:0] {IDLE, LOADING, ARMED} key_state_t;

  key_state_t       state, state_nxt;
  logic [KEY_W-1:0] sr, sr_shifted, key_q;
  logic [CNT_W-1:0] cnt, cnt_shift;
  logic             commit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    sr_shifted = {sr[KEY_W-2:0], key_bit_i};
    cnt_shift  = (state == LOADING) ? cnt + CNT_W'(1) : CNT_W'(1);
    commit     = key_shift_i && !key_clear_i && (cnt_shift == CNT_W'(KEY_W));
    state_nxt  = state;
    if (key_clear_i)      state_nxt = IDLE;
    else if (commit)      state_nxt = ARMED;
    else if (key_shift_i) state_nxt = LOADING;
  end

  // key_q only ever receives a complete shift register image
  always_ff @(posedge clk_i) begin
    if (!rst_ni || key_clear_i) begin
      sr    <= '0;
      cnt   <= '0;
      key_q <= '0;
    end else if (key_shift_i) begin
      sr  <= sr_shifted;
      cnt <= cnt_shift;
      if (commit) key_q <= sr_shifted;
    end
  end

  assign key_armed_o = (state == ARMED);
  assign lock_ok_o   = key_armed_o && (key_q == KEY_CORRECT);

  logic             adv_p1, adv_p2, accept;
  logic             vld_p1, vld_p2;
  logic [WIDTH:0]   mask;
  logic [WIDTH-1:0] g_p0, p_p0;
  logic [NGRP-1:0]  grp_g_p0, grp_p_p0;

  assign adv_p2      = !vld_p2 || out_ready_i;
  assign adv_p1      = !vld_p1 || adv_p2;
  assign in_ready_o  = (state != LOADING) && adv_p1;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = vld_p2;

  // Mask: key difference folded into (WIDTH+1)-bit chunks, unarmed acts as key 0
  always_comb begin
    logic [KEY_W-1:0] d;
    d    = (key_armed_o ? key_q : '0) ^ KEY_CORRECT;
    mask = '0;
    for (int i = 0; i < KEY_W; i++) mask[i % (WIDTH + 1)] = mask[i % (WIDTH + 1)] ^ d[i];
  end

  always_comb begin
    logic lc;
    g_p0 = add1_i & add2_i;
    p_p0 = add1_i ^ add2_i;
    for (int k = 0; k < NGRP; k++) begin
      lc = 1'b0;
      for (int j = 0; j < BLOCK; j++) lc = g_p0[k*BLOCK+j] | (p_p0[k*BLOCK+j] & lc);
      grp_g_p0[k] = lc;
      grp_p_p0[k] = &p_p0[k*BLOCK +: BLOCK];
    end
  end

  // Stage 1: bit and group generate/propagate plus the mask captured at acceptance
  logic [WIDTH-1:0] g_p1, p_p1;
  logic [NGRP-1:0]  grp_g_p1, grp_p_p1;
  logic             cin_p1;
  logic [WIDTH:0]   mask_p1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)     vld_p1 <= 1'b0;
    else if (adv_p1) vld_p1 <= accept;
  end

  always_ff @(posedge clk_i) begin
    if (adv_p1 && accept) begin
      g_p1     <= g_p0;
      p_p1     <= p_p0;
      grp_g_p1 <= grp_g_p0;
      grp_p_p1 <= grp_p_p0;
      cin_p1   <= cin_i;
      mask_p1  <= mask;
    end
  end

  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;

  always_comb begin
    logic gc, bc;
    gc     = cin_p1;
    sum_p1 = '0;
    for (int k = 0; k < NGRP; k++) begin
      bc = gc;
      for (int j = 0; j < BLOCK; j++) begin
        sum_p1[k*BLOCK+j] = p_p1[k*BLOCK+j] ^ bc;
        bc = g_p1[k*BLOCK+j] | (p_p1[k*BLOCK+j] & bc);
      end
      gc = grp_g_p1[k] | (grp_p_p1[k] & gc);
    end
    cout_p1 = gc;
  end

  // Stage 2: resolved carries and masked sum
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p2   <= 1'b0;
      result_o <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) result_o <= {cout_p1, sum_p1} ^ mask_p1;
    end
  end

endmodule

// File: tb/tb_locked_cla_pipe.sv
// Directed bench for locked_cla_pipe: latency, key loading, masking, stalls and resets.
module tb_locked_cla_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] add1 = '0, add2 = '0;
  logic        cin = 1'b0, in_valid = 1'b0, in_ready;
  logic [16:0] result;
  logic        out_valid, out_ready = 1'b1;
  logic        key_shift = 1'b0, key_bit = 1'b0, key_clear = 1'b0;
  logic        key_armed, lock_ok;

  int checks = 0;
  int failures = 0;
  logic [16:0] got_q[$];
  bit rs;

  localparam logic [31:0] KEY_OK = 32'hD7D41D23;

  locked_cla_pipe dut (
    .clk_i(clk), .rst_ni(rst_n), .add1_i(add1), .add2_i(add2), .cin_i(cin),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .result_o(result),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .key_shift_i(key_shift),
    .key_bit_i(key_bit), .key_clear_i(key_clear), .key_armed_o(key_armed),
    .lock_ok_o(lock_ok)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && out_valid && out_ready) got_q.push_back(result);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    add1 = a; add2 = b; cin = c; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (n == 50) check_val("send_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic shift_bits(input logic [31:0] k, input int n, output bit ready_seen);
    ready_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      key_shift = 1'b1; key_bit = k[31-i];
      step();
      if (i != 31 && in_ready) ready_seen = 1'b1;
    end
    key_shift = 1'b0;
  endtask

  task automatic load_key(input logic [31:0] k);
    bit seen;
    shift_bits(k, 32, seen);
    check_val("load_ready_low", seen, 0);
  endtask

  task automatic drain(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 50) begin step(); t++; end
    repeat (3) step();
    check_val("result_count", got_q.size(), n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) step();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_result", result, 0);
    check_val("rst_armed", key_armed, 0);
    rst_n = 1'b1;
    check_val("rel_in_ready", in_ready, 1);
    check_val("rel_out_valid", out_valid, 0);
    check_val("rel_lock_ok", lock_ok, 0);

    // No key: latency and default mask
    add1 = 16'h0000; add2 = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_val("lat_edge1_valid", out_valid, 0);
    step();
    check_val("lat_edge2_valid", out_valid, 1);
    check_val("nokey_result", result, 17'h076C8);
    check_val("nokey_lock_ok", lock_ok, 0);
    step();
    got_q.delete();

    // Correct key
    load_key(KEY_OK);
    check_val("ok_armed", key_armed, 1);
    check_val("ok_lock", lock_ok, 1);
    send(16'h29AF, 16'h7A1B, 1'b0);
    drain(1);
    check_val("ok_result", got_q[0], 17'h0A3CA);
    got_q.delete();

    // Wrong keys
    load_key(32'hD7D41D03);
    check_val("bad1_armed", key_armed, 1);
    check_val("bad1_lock", lock_ok, 0);
    send(16'h29AF, 16'h7A1B, 1'b0);
    drain(1);
    check_val("bad1_result", got_q[0], 17'h0A3EA);
    got_q.delete();
    load_key(32'h00D41D23);
    send(16'h8943, 16'hFFFF, 1'b0);
    drain(1);
    check_val("bad2_result", got_q[0], 17'h1E2C2);
    got_q.delete();

    // Back-to-back with output stall
    load_key(KEY_OK);
    out_ready = 1'b0;
    send(16'h5555, 16'hAAAA, 1'b0);
    send(16'h8051, 16'h8086, 1'b0);
    check_val("stall_in_ready", in_ready, 0);
    check_val("stall_out_valid", out_valid, 1);
    check_val("stall_result0", result, 17'h0FFFF);
    step(); step();
    check_val("stall_hold_result", result, 17'h0FFFF);
    check_val("stall_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    drain(2);
    check_val("stall_first", got_q[0], 17'h0FFFF);
    check_val("stall_second", got_q[1], 17'h100D7);
    got_q.delete();

    // New key while two results are in flight
    send(16'h1234, 16'h1111, 1'b1);
    send(16'h0F0F, 16'h00F0, 1'b0);
    shift_bits(32'hD7D41D03, 32, rs);
    check_val("inflight_ready_low", rs, 0);
    drain(2);
    check_val("inflight_first", got_q[0], 17'h02346);
    check_val("inflight_second", got_q[1], 17'h00FFF);
    got_q.delete();
    send(16'h29AF, 16'h7A1B, 1'b0);
    drain(1);
    check_val("newkey_result", got_q[0], 17'h0A3EA);
    got_q.delete();

    // Clear wins over shift at bit 20
    shift_bits(KEY_OK, 19, rs);
    key_clear = 1'b1; key_shift = 1'b1; key_bit = 1'b1;
    step();
    key_clear = 1'b0; key_shift = 1'b0;
    check_val("clr_armed", key_armed, 0);
    check_val("clr_lock", lock_ok, 0);
    check_val("clr_idle_ready", in_ready, 1);
    send(16'h0000, 16'h0000, 1'b1);
    drain(1);
    check_val("clr_result", got_q[0], 17'h076C8);
    got_q.delete();
    load_key(KEY_OK);
    check_val("reload_lock", lock_ok, 1);
    send(16'h29AF, 16'h7A1B, 1'b0);
    drain(1);
    check_val("reload_result", got_q[0], 17'h0A3CA);
    got_q.delete();

    // Reset during a stalled transfer and a partial key load
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    step();
    shift_bits(KEY_OK, 10, rs);
    rst_n = 1'b0;
    step(); step();
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_result", result, 0);
    check_val("midrst_armed", key_armed, 0);
    rst_n = 1'b1;
    check_val("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    got_q.delete();
    send(16'h0000, 16'h0000, 1'b0);
    drain(1);
    check_val("midrst_result_mask", got_q[0], 17'h076C9);
    check_val("midrst_lock", lock_ok, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
